// File: rtl/stream_buffer.sv
// stream_buffer
// -------------
// Small first-word fall-through FIFO between a valid/ready producer and a
// valid/ready consumer. Words pushed into an empty buffer appear on sOut one
// cycle later, and they leave in the order they arrived.
//
// Parameters
//   N      : stream word width in bits
//   DEPTH  : storage capacity in words (power of two, at least 2)
//
// Ports
//   clk        : single clock; all state changes on its rising edge
//   nrst       : asynchronous active-low reset
//   sIn        : upstream word
//   sIn_valid  : sIn carries a word this cycle
//   sIn_ready  : buffer can accept a word this cycle
//   sOut       : head word (0 while the buffer is empty)
//   sOut_valid : sOut carries a word
//   sOut_ready : consumer takes sOut this cycle
//   flush      : synchronous discard of all buffered words
//   count      : number of buffered words, 0..DEPTH
module stream_buffer #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N-1:0]             sIn,
  input  logic                     sIn_valid,
  output logic                     sIn_ready,
  output logic [N-1:0]             sOut,
  output logic                     sOut_valid,
  input  logic                     sOut_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Storage is deliberately left without a reset; sOut is masked while the
  // buffer is empty so stale contents never leak out.
  logic [N-1:0]  mem_q [DEPTH];

  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic doPush;
  logic doPop;

  // Handshake flags are derived from registered state only, so sOut_ready
  // never reaches sIn_ready combinationally. A full buffer refuses a push
  // even when a pop happens in the same cycle.
  assign sIn_ready  = (count_q < FULL);
  assign sOut_valid = (count_q != '0);
  assign sOut       = sOut_valid ? mem_q[rdPtr_q] : '0;
  assign count      = count_q;

  assign doPush = sIn_valid && sIn_ready;
  assign doPop  = sOut_valid && sOut_ready;

  // Next-state computation. Flush wins over any push or pop. Pointers are
  // exactly AW bits wide, so wrapping modulo DEPTH falls out of the
  // arithmetic with no special case.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (doPush && !doPop) begin
        count_d = count_q + CW'(1);
      end else if (doPop && !doPush) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state with asynchronous reset; reset throws away whatever was
  // buffered so the first push afterwards is the first word read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Data storage write port; a flushed cycle drops the offered word.
  always_ff @(posedge clk) begin
    if (doPush && !flush) begin
      mem_q[wrPtr_q] <= sIn;
    end
  end

endmodule

// File: tb/tb_stream_buffer.sv
module tb_stream_buffer;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         nrst;
  logic [N-1:0] sIn;
  logic         sIn_valid;
  logic         sIn_ready;
  logic [N-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready;
  logic         flush;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference contents of the buffer, head at index 0.
  logic [N-1:0] model[$];

  stream_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .sIn        (sIn),
    .sIn_valid  (sIn_valid),
    .sIn_ready  (sIn_ready),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready),
    .flush      (flush),
    .count      (count)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: the buffer is a queue of at most DEPTH words. A push
  // happens when the producer is valid and the queue is not full, a pop when
  // the consumer is ready and the queue is non-empty, and flush empties it.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      model.delete();
    end else begin
      automatic bit canPush = sIn_valid && (model.size() < DEPTH);
      automatic bit canPop  = sOut_ready && (model.size() != 0);
      if (flush) begin
        model.delete();
      end else begin
        if (canPop) void'(model.pop_front());
        if (canPush) model.push_back(sIn);
      end
    end
  end

  // Every falling edge the registered outputs are compared with what the
  // model says they must be.
  always @(negedge clk) begin
    checkOutput("count", int'(count), model.size());
    checkOutput("sOut_valid", int'(sOut_valid), int'(model.size() != 0));
    checkOutput("sIn_ready", int'(sIn_ready), int'(model.size() < DEPTH));
    checkOutput("sOut", int'(sOut), (model.size() != 0) ? int'(model[0]) : 0);
  end

  // Drives one cycle of inputs after a falling edge and returns just after
  // the following rising edge, so outputs reflect that edge.
  task automatic applyStimulus(input bit v, input int d, input bit r, input bit f);
    @(negedge clk);
    sIn_valid  = v;
    sIn        = N'(d);
    sOut_ready = r;
    flush      = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0;
    sIn = '0;
    sIn_valid = 1'b0;
    sOut_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;

    // Reset state.
    #1;
    checkOutput("reset count", int'(count), 0);
    checkOutput("reset sOut_valid", int'(sOut_valid), 0);
    checkOutput("reset sOut", int'(sOut), 0);
    checkOutput("reset sIn_ready", int'(sIn_ready), 1);

    // Push 1,2,3 with the consumer stalled.
    for (int i = 1; i <= 3; i++) applyStimulus(1, i, 0, 0);
    checkOutput("push3 count", int'(count), 3);
    checkOutput("push3 sOut", int'(sOut), 1);
    checkOutput("push3 sOut_valid", int'(sOut_valid), 1);
    checkOutput("push3 sIn_ready", int'(sIn_ready), 1);
    applyStimulus(0, 0, 0, 1);

    // Fill past capacity, then drain.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, i, 0, 0);
      if (i == 4) begin
        checkOutput("full count", int'(count), 4);
        checkOutput("full sIn_ready", int'(sIn_ready), 0);
      end
    end
    checkOutput("overflow count", int'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain sOut", int'(sOut), i);
      applyStimulus(0, 0, 1, 0);
    end
    checkOutput("drained sOut_valid", int'(sOut_valid), 0);

    // Streaming pass-through; pointers wrap twice over ten words.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, i, 1, 0);
      checkOutput("stream sOut", int'(sOut), i);
      checkOutput("stream count", int'(count), 1);
    end
    applyStimulus(0, 0, 1, 0);

    // Full buffer with both sides active: pop only, then push and pop.
    for (int i = 11; i <= 14; i++) applyStimulus(1, i, 0, 0);
    applyStimulus(1, 15, 1, 0);
    checkOutput("full pop count", int'(count), 3);
    checkOutput("full pop sOut", int'(sOut), 12);
    applyStimulus(1, 16, 1, 0);
    checkOutput("pushpop count", int'(count), 3);
    checkOutput("pushpop sOut", int'(sOut), 13);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("order after refused push", int'(sOut), 16);
    applyStimulus(0, 0, 1, 0);

    // Flush drops the word offered in the same cycle.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 2, 0, 0);
    checkOutput("preflush count", int'(count), 2);
    applyStimulus(1, 9, 0, 1);
    checkOutput("flush count", int'(count), 0);
    checkOutput("flush sOut_valid", int'(sOut_valid), 0);
    checkOutput("flush sOut", int'(sOut), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("flush no 9", int'(sOut_valid), 0);

    // Asynchronous reset between edges with three words buffered.
    for (int i = 1; i <= 3; i++) applyStimulus(1, i, 0, 0);
    sIn_valid = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("async count", int'(count), 0);
    checkOutput("async sOut_valid", int'(sOut_valid), 0);
    checkOutput("async sIn_ready", int'(sIn_ready), 1);
    checkOutput("async sOut", int'(sOut), 0);
    @(negedge clk);
    nrst = 1'b1;
    applyStimulus(1, 7, 0, 0);
    checkOutput("post reset sOut", int'(sOut), 7);
    checkOutput("post reset count", int'(count), 1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_buffer.md
STREAM_BUFFER -- requirements
Module: stream_buffer

Interface
REQ-001 SHALL have parameter N, default 8 (`intN`), giving the stream word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the storage capacity in words; it SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sIn  input  N  upstream stream word.
REQ-006 SHALL have port sIn_valid  input  1  sIn carries a word this cycle.
REQ-007 SHALL have port sIn_ready  output  1  buffer accepts a word this cycle.
REQ-008 SHALL have port sOut  output  N  head word offered to the downstream stream consumer (pop primitive).
REQ-009 SHALL have port sOut_valid  output  1  sOut carries a word.
REQ-010 SHALL have port sOut_ready  input  1  consumer takes sOut this cycle.
REQ-011 SHALL have port flush  input  1  synchronous discard of all buffered words.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of buffered words, 0..DEPTH.

Function
REQ-013 SHALL push on a rising edge with sIn_valid && sIn_ready, writing sIn at the write pointer.
REQ-014 SHALL pop on a rising edge with sOut_valid && sOut_ready, advancing the read pointer.
REQ-015 SHALL drive sIn_ready = (count < DEPTH), from registered state only; there SHALL be no combinational path from sOut_ready to sIn_ready.
REQ-016 SHALL drive sOut_valid = (count != 0) and sOut = the entry at the read pointer (first-word fall-through); sOut SHALL be 0 when count == 0.
REQ-017 SHALL have a latency of one cycle: a word pushed at edge k is valid on sOut after edge k when the buffer was empty.
REQ-018 SHALL deliver words in push order with no loss or duplication.
REQ-019 SHALL update count by +1 on push only, -1 on pop only, and 0 on simultaneous push and pop.
REQ-020 SHALL allow simultaneous push and pop when 0 < count < DEPTH.
REQ-021 SHALL not push when count == DEPTH (sIn_ready=0), even if a pop occurs in the same cycle.
REQ-022 SHALL never pop when count == 0 (sOut_valid=0), regardless of sOut_ready.
REQ-023 SHALL wrap read and write pointers modulo DEPTH without a bubble.
REQ-024 SHALL, on flush high at an edge, set count and both pointers to 0; flush SHALL override any push or pop in the same cycle, and the sIn word offered in that cycle SHALL be dropped.
REQ-025 SHALL ignore sIn contents when sIn_valid=0 and hold all state when there is neither push, pop nor flush.

Reset
REQ-026 SHALL, when nrst is low, immediately (without a clock) force count=0, read pointer=0, write pointer=0, sOut_valid=0, sOut=0, sIn_ready=1.
REQ-027 SHALL discard buffered words when reset is asserted mid-operation; the first push after nrst rises SHALL be the first word read.
REQ-028 SHALL leave storage contents unreset; they SHALL never be observable while count == 0.

Verification (N=8, DEPTH=4)
REQ-029 SHALL be verified by: reset, then push 1,2,3 with sOut_ready=0 -> count=3, sOut=1, sOut_valid=1, sIn_ready=1.
REQ-030 SHALL be verified by: push 1..5 back-to-back with sOut_ready=0 -> count=4 and sIn_ready=0 after the 4th push; 5 is not accepted; then sOut_ready=1 -> 1,2,3,4 delivered on consecutive cycles, then sOut_valid=0.
REQ-031 SHALL be verified by: sIn incrementing from 1 with sIn_valid=1 and sOut_ready=1 for 10 cycles -> sOut follows sIn one cycle later, count stays 1, and both pointers wrap twice without a bubble.
REQ-032 SHALL be verified by: buffer at count=4 with sOut_ready=1 and sIn_valid=1 -> one pop and no push in that cycle, count=3; the next cycle has both push and pop, count=3.
REQ-033 SHALL be verified by: count=2, then flush=1 with sIn_valid=1 and sIn=9 -> count=0, sOut_valid=0, sOut=0 next cycle, and 9 is never delivered.
REQ-034 SHALL be verified by: nrst pulled low between clock edges at count=3 -> count=0, sOut_valid=0, sIn_ready=1 before the next edge; after nrst rises, push 7 -> sOut=7.
